// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter and its watchdog.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; master is the arbiter, slave the environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BS_W = DATA_W / 8;

  logic              i_req;
  logic              i_wen;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_datain;
  logic [BS_W-1:0]   i_byte_sel;
  logic              i_done;
  logic [DATA_W-1:0] i_dataout;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_datain;
  logic [BS_W-1:0]   d_byte_sel;
  logic              d_done;
  logic [DATA_W-1:0] d_dataout;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic [BS_W-1:0]   mem_byte_sel;
  logic [DATA_W-1:0] mem_dataout;
  logic              mem_ready;

  logic              timeout_err;

  modport master (
    input  i_req, i_wen, i_address, i_datain, i_byte_sel,
    output i_done, i_dataout,
    input  d_req, d_wen, d_address, d_datain, d_byte_sel,
    output d_done, d_dataout,
    output mem_ren, mem_wen, mem_address, mem_datain, mem_byte_sel,
    input  mem_dataout, mem_ready,
    output timeout_err
  );

  modport slave (
    output i_req, i_wen, i_address, i_datain, i_byte_sel,
    input  i_done, i_dataout,
    output d_req, d_wen, d_address, d_datain, d_byte_sel,
    input  d_done, d_dataout,
    input  mem_ren, mem_wen, mem_address, mem_datain, mem_byte_sel,
    output mem_dataout, mem_ready,
    input  timeout_err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Cycle counter that flags expiry after TIMEOUT enabled cycles; clear has priority over enable.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Grants the instruction or data cache one memory transaction at a time, with watchdog abort.
// Macro ARB_ROUND_ROBIN_EN: under contention the side not granted last wins (default: data first).
//   state  | meaning
//   IDLE   | waiting for a request
//   BUSY_I | memory driven for the instruction side
//   BUSY_D | memory driven for the data side
//   DONE   | one-cycle bubble so the winner can drop its request
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam int BS_W = DATA_W / 8;

  arb_state_t        state;
  logic              lat_wen;
  logic [ADDR_W-1:0] lat_address;
  logic [DATA_W-1:0] lat_datain;
  logic [BS_W-1:0]   lat_byte_sel;
  logic              grant_d;
  logic              sel_wen;
  logic              busy;
  logic              expired;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign sel_wen = grant_d ? bus.d_wen : bus.i_wen;

  always_comb begin
    grant_d = bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.i_req && bus.d_req) grant_d = (last_grant == REQ_I);
`endif
  end

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  // Address, data and byte enables come straight from the grant-edge latches.
  assign bus.mem_address  = lat_address;
  assign bus.mem_datain   = lat_datain;
  assign bus.mem_byte_sel = lat_byte_sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      lat_wen         <= 1'b0;
      lat_address     <= '0;
      lat_datain      <= '0;
      lat_byte_sel    <= '0;
      bus.mem_ren     <= 1'b0;
      bus.mem_wen     <= 1'b0;
      bus.i_done      <= 1'b0;
      bus.d_done      <= 1'b0;
      bus.i_dataout   <= '0;
      bus.d_dataout   <= '0;
      bus.timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant      <= REQ_I;
`endif
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            lat_wen      <= sel_wen;
            lat_address  <= grant_d ? bus.d_address  : bus.i_address;
            lat_datain   <= grant_d ? bus.d_datain   : bus.i_datain;
            lat_byte_sel <= grant_d ? bus.d_byte_sel : bus.i_byte_sel;
            bus.mem_ren  <= !sel_wen;
            bus.mem_wen  <= sel_wen;
            state        <= grant_d ? BUSY_D : BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant   <= grant_d ? REQ_D : REQ_I;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          // mem_ready wins over a watchdog expiry landing in the same cycle.
          if (bus.mem_ready || expired) begin
            bus.mem_ren <= 1'b0;
            bus.mem_wen <= 1'b0;
            state       <= DONE;
            if (state == BUSY_D) bus.d_done <= 1'b1;
            else                 bus.i_done <= 1'b1;
            if (bus.mem_ready) begin
              if (!lat_wen) begin
                if (state == BUSY_D) bus.d_dataout <= bus.mem_dataout;
                else                 bus.i_dataout <= bus.mem_dataout;
              end
            end else begin
              bus.timeout_err <= 1'b1;
              if (state == BUSY_D) bus.d_dataout <= '0;
              else                 bus.i_dataout <= '0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing memory port between the instruction-side and data-side cache controllers.
- Accepts one miss/writeback request per side, selects one, drives the memory for the whole transaction until the memory's ready strobe, then returns data and a one-cycle done pulse to the winner.
- Includes a watchdog that aborts transactions the memory never completes.

Parameters:
- ADDR_W, 32, address width in bits (word address, already shifted >>2 by the requester).
- DATA_W, 32, data width in bits; byte-select width is DATA_W/8.
- TIMEOUT, 64, maximum cycles to wait for mem_ready before abort; must be >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_req  in  1  instruction-side request, held high until i_done
- i_wen  in  1  instruction-side write (1) / read (0)
- i_address  in  ADDR_W  instruction-side word address
- i_datain  in  DATA_W  instruction-side write data
- i_byte_sel  in  DATA_W/8  instruction-side byte enables
- i_done  out  1  one-cycle completion pulse to instruction side
- i_dataout  out  DATA_W  read data to instruction side, valid with i_done
- d_req, d_wen, d_address, d_datain, d_byte_sel  in  same as i_*  data-side request
- d_done  out  1  one-cycle completion pulse to data side
- d_dataout  out  DATA_W  read data to data side, valid with d_done
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_address  out  ADDR_W  memory address
- mem_datain  out  DATA_W  memory write data
- mem_byte_sel  out  DATA_W/8  memory byte enables
- mem_dataout  in  DATA_W  memory read data
- mem_ready  in  1  memory completion strobe (memsig)
- timeout_err  out  1  sticky error flag, set on watchdog abort

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- Reset (reset==0 at posedge):
  - state=IDLE; all outputs 0; watchdog count=0; timeout_err=0; last-grant=I.
  - Reset mid-transaction drops the transaction with no done pulse.
- IDLE:
  - Both requests high: data side wins (fixed priority).
  - Only one request high: that side wins.
  - Winning request's address, data, byte_sel and wen are latched into internal registers on the grant edge.
  - Next state is BUSY_I or BUSY_D.
  - With no request, stay in IDLE; mem_ren=mem_wen=0.
- BUSY_x:
  - mem_* driven from the latched registers, registered outputs.
  - mem_ren = !latched_wen; mem_wen = latched_wen.
  - Requester input changes during BUSY are ignored.
  - Watchdog increments each cycle.
  - On mem_ready=1: capture mem_dataout into x_dataout, pulse x_done for exactly one cycle, deassert mem_ren/mem_wen, go to DONE.
  - For writes, x_dataout holds its previous value.
  - Watchdog reaching TIMEOUT-1 without mem_ready: set timeout_err, pulse x_done, x_dataout=0, go to DONE.
- DONE:
  - One-cycle bubble, memory idle, so the requester can drop its request.
  - Always returns to IDLE.
  - Minimum occupancy is grant + 1 memory cycle + DONE. Back-to-back requests from one side are served every 3 cycles for a 1-cycle memory.
- Latency: request seen in IDLE at cycle N → mem enables active from N+1 → x_done in the cycle after mem_ready.
- timeout_err stays sticky until reset.
- Both done outputs are never high in the same cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the side not granted last wins. The last-grant register updates on every grant; I and D alternate under continuous contention.
- Undefined: fixed data-side priority; the last-grant register is not implemented.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DONE=2'd3);
  - requester-ID constants (REQ_I=1'b0, REQ_D=1'b1);
  - the default TIMEOUT.
- One natural sub-module, mem_arb_watchdog: counter with clear/enable inputs and an expired output, reused by future bus masters.

Test Plan:
- Single i_req read, address 0x10, memory returns 0xDEADBEEF one cycle after enables → mem_ren=1 with mem_address=0x10; i_done pulses once with i_dataout=0xDEADBEEF; d_done stays 0.
- i_req and d_req rise together (d: write 0xCAFEF00D, byte_sel 4'b0011) → D served first with mem_wen=1 and mem_byte_sel=4'b0011; I served after DONE, with done order d then i.
- Continuous contention with ARB_ROUND_ROBIN_EN defined → grants alternate D,I,D,I over 4 transactions. Without the macro, D starves I while d_req remains high.
- Memory never asserts mem_ready, TIMEOUT=8 → x_done after 8 BUSY cycles; x_dataout=0; timeout_err=1 and stays 1 through later good transactions.
- reset driven low during BUSY_D → next edge: state IDLE, mem_ren/mem_wen=0, no d_done pulse; a new request after release is served normally.
- Requester changes d_address from 0x20 to 0x30 mid-BUSY → mem_address stays 0x20 until done.
